// File: rtl/uart_mapped_fifo.sv
// Byte-bus UART peripheral: TX/RX FIFOs, 8N1 serialisers, programmable divisor,
// loopback and a prioritised level interrupt.
module uart_mapped_fifo #(
  parameter int TX_DEPTH     = 16,
  parameter int RX_DEPTH     = 16,
  parameter int DIV_WIDTH    = 16,
  parameter int RESET_DIV    = 433,
  parameter int RX_IRQ_LEVEL = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cs,
  input  logic       rd,
  input  logic       wr,
  input  logic [2:0] addr,
  input  logic [7:0] in_data,
  output logic [7:0] out_data,
  input  logic       rx_in,
  output logic       tx_out,
  output logic       irq,
  output logic [2:0] irq_id,
  output logic [1:0] dbg_tx_state,
  output logic [1:0] dbg_rx_state
);
  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam logic [TXA:0] TX_FULL_LVL = (TXA+1)'(TX_DEPTH);
  localparam logic [RXA:0] RX_FULL_LVL = (RXA+1)'(RX_DEPTH);
  localparam logic [RXA:0] RX_IRQ_LVL  = (RXA+1)'(RX_IRQ_LEVEL);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

  // Bus access: one operation per strobe assertion, fired on the first clock where
  // cs and either strobe are low (write wins); read data lands on out_data a clock later.
  logic access, access_q, fire, do_wr, do_rd;
  assign access = !cs && (!rd || !wr);
  assign fire   = access && !access_q;
  assign do_wr  = fire && !wr;
  assign do_rd  = fire && wr;

  logic [5:0]           ctrl;
  logic [DIV_WIDTH-1:0] div;
  logic [15:0]          div_ext;
  logic                 rx_ovr, frame_err, tx_ovf;
  assign div_ext = 16'(div);

  // TX FIFO
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TXA-1:0] tx_wp, tx_rp;
  logic [TXA:0]   tx_cnt;
  logic           tx_empty, tx_full, tx_push, tx_pop;
  // RX FIFO
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RXA-1:0] rx_wp, rx_rp;
  logic [RXA:0]   rx_cnt;
  logic           rx_empty, rx_full, rx_push, rx_pop;

  ser_state_t           tx_state, rx_state;
  logic                 tx_line;
  logic [DIV_WIDTH-1:0] tx_bcnt, tx_div;
  logic [2:0]           tx_bit;
  logic [7:0]           tx_shift;
  logic                 tx_bit_end, tx_busy;

  logic                 rx_sync1, rx_sync2, rx_line, rx_prev;
  logic [DIV_WIDTH-1:0] rx_bcnt, rx_div, rx_half;
  logic [2:0]           rx_bit;
  logic [7:0]           rx_shift;
  logic                 rx_stop_sample;
  logic [DIV_WIDTH:0]   half_full;
  logic [DIV_WIDTH-1:0] half_m1;

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == TX_FULL_LVL);
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == RX_FULL_LVL);
  assign tx_busy  = (tx_state != S_IDLE);

  assign tx_push = do_wr && (addr == 3'd0) && !tx_full;
  assign tx_pop  = (tx_state == S_IDLE) && ctrl[0] && !tx_empty;
  assign rx_stop_sample = (rx_state == S_STOP) && (rx_bcnt == rx_div);
  assign rx_push = rx_stop_sample && !rx_full;
  assign rx_pop  = do_rd && (addr == 3'd0) && !rx_empty;

  assign tx_out       = ctrl[2] ? 1'b1 : tx_line;
  assign rx_line      = ctrl[2] ? tx_line : rx_sync2;
  assign dbg_tx_state = tx_state;
  assign dbg_rx_state = rx_state;

  // Start-bit wait of (DIV+1)/2 clocks, stored as a terminal count.
  assign half_full = ({1'b0, div} + (DIV_WIDTH+1)'(1)) >> 1;
  assign half_m1   = (half_full == '0) ? '0 : DIV_WIDTH'(half_full - (DIV_WIDTH+1)'(1));

  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wp] <= in_data;
    if (rx_push) rx_mem[rx_wp] <= rx_shift;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
    end
  end

  assign tx_bit_end = (tx_bcnt == tx_div);

  always_ff @(posedge clock) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_line  <= 1'b1;
      tx_bcnt  <= '0;
      tx_div   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      if (tx_state != S_IDLE) tx_bcnt <= tx_bit_end ? '0 : tx_bcnt + 1'b1;
      unique case (tx_state)
        S_IDLE: if (tx_pop) begin
          tx_shift <= tx_mem[tx_rp];
          tx_div   <= div;
          tx_bcnt  <= '0;
          tx_line  <= 1'b0;
          tx_state <= S_START;
        end
        S_START: if (tx_bit_end) begin
          tx_line  <= tx_shift[0];
          tx_bit   <= '0;
          tx_state <= S_DATA;
        end
        S_DATA: if (tx_bit_end) begin
          if (tx_bit == 3'd7) begin
            tx_line  <= 1'b1;
            tx_state <= S_STOP;
          end else begin
            tx_bit   <= tx_bit + 1'b1;
            tx_shift <= tx_shift >> 1;
            tx_line  <= tx_shift[1];
          end
        end
        S_STOP: if (tx_bit_end) tx_state <= S_IDLE;
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_bcnt  <= '0;
      rx_div   <= '0;
      rx_half  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_sync1 <= rx_in;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_line;
      unique case (rx_state)
        S_IDLE: if (ctrl[1] && rx_prev && !rx_line) begin
          rx_div   <= div;
          rx_half  <= half_m1;
          rx_bcnt  <= '0;
          rx_state <= S_START;
        end
        S_START: begin
          if (rx_bcnt == rx_half) begin
            rx_bcnt  <= '0;
            rx_bit   <= '0;
            rx_state <= rx_line ? S_IDLE : S_DATA;
          end else rx_bcnt <= rx_bcnt + 1'b1;
        end
        S_DATA: begin
          if (rx_bcnt == rx_div) begin
            rx_bcnt  <= '0;
            rx_shift <= {rx_line, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
          end else rx_bcnt <= rx_bcnt + 1'b1;
        end
        S_STOP: begin
          if (rx_stop_sample) rx_state <= S_IDLE;
          else rx_bcnt <= rx_bcnt + 1'b1;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // Sticky flags: a new event in the same clock as a clear keeps the flag set.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_ovr <= 1'b0; frame_err <= 1'b0; tx_ovf <= 1'b0;
    end else begin
      if (rx_stop_sample && rx_full) rx_ovr <= 1'b1;
      else if (do_wr && addr == 3'd5 && in_data[4]) rx_ovr <= 1'b0;
      if (rx_stop_sample && !rx_line) frame_err <= 1'b1;
      else if (do_wr && addr == 3'd5 && in_data[5]) frame_err <= 1'b0;
      if (do_wr && addr == 3'd0 && tx_full) tx_ovf <= 1'b1;
      else if (do_wr && addr == 3'd5 && in_data[7]) tx_ovf <= 1'b0;
    end
  end

  logic [7:0] status, rd_mux;
  logic       err_p, rx_p, tx_p;
  assign status = {tx_ovf, tx_busy, frame_err, rx_ovr, tx_full, tx_empty, rx_full, !rx_empty};
  assign err_p  = ctrl[5] && (rx_ovr || frame_err || tx_ovf);
  assign rx_p   = ctrl[3] && (rx_cnt >= RX_IRQ_LVL);
  assign tx_p   = ctrl[4] && tx_empty && !tx_busy;

  always_comb begin
    rd_mux = '0;
    unique case (addr)
      3'd0: rd_mux = rx_empty ? 8'h00 : rx_mem[rx_rp];
      3'd1: rd_mux = status;
      3'd2: rd_mux = {2'b00, ctrl};
      3'd3: rd_mux = div_ext[7:0];
      3'd4: rd_mux = div_ext[15:8];
      3'd5: rd_mux = {5'b0, irq_id};
      3'd6: rd_mux = 8'(rx_cnt);
      3'd7: rd_mux = 8'(tx_cnt);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      access_q <= 1'b0;
      ctrl     <= '0;
      div      <= DIV_WIDTH'(RESET_DIV);
      out_data <= '0;
      irq      <= 1'b0;
      irq_id   <= '0;
    end else begin
      access_q <= access;
      if (do_wr) begin
        unique case (addr)
          3'd2: ctrl <= in_data[5:0];
          3'd3: div  <= DIV_WIDTH'({div_ext[15:8], in_data});
          3'd4: div  <= DIV_WIDTH'({in_data, div_ext[7:0]});
          default: ;
        endcase
      end
      if (do_rd) out_data <= rd_mux;
      irq    <= err_p || rx_p || tx_p;
      irq_id <= err_p ? 3'd1 : rx_p ? 3'd2 : tx_p ? 3'd3 : 3'd0;
    end
  end
endmodule

// File: tb/tb_uart_mapped_fifo.sv
// Directed + randomized bench for uart_mapped_fifo; expectations come from frame rules
// and a byte-queue model of what should travel TX -> RX.
module tb_uart_mapped_fifo;
  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset, cs, rd, wr, rx_in;
  logic [2:0] addr;
  logic [7:0] in_data;
  logic [7:0] out_data;
  logic       tx_out, irq;
  logic [2:0] irq_id;
  logic [1:0] dbg_tx_state, dbg_rx_state;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  uart_mapped_fifo #(.TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .cs(cs), .rd(rd), .wr(wr), .addr(addr),
    .in_data(in_data), .out_data(out_data), .rx_in(rx_in), .tx_out(tx_out),
    .irq(irq), .irq_id(irq_id), .dbg_tx_state(dbg_tx_state), .dbg_rx_state(dbg_rx_state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %02h, want %02h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clock); cs = 1'b0; wr = 1'b0; addr = a; in_data = d;
    @(negedge clock); cs = 1'b1; wr = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clock); cs = 1'b0; rd = 1'b0; addr = a;
    @(negedge clock); d = out_data; cs = 1'b1; rd = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] got;
    bus_read(a, got);
    check(tag, got, exp);
  endtask

  task automatic set_div(input logic [15:0] dv);
    bus_write(3'd3, dv[7:0]);
    bus_write(3'd4, dv[15:8]);
  endtask

  // Line level during bit k of an 8N1 frame (k=0 start, 1..8 data LSB first, 9 stop).
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  task automatic wait_irq(input int budget);
    int n = 0;
    while (irq !== 1'b1 && n < budget) begin @(negedge clock); n++; end
  endtask

  task automatic check_tx_frame(input logic [7:0] b, input int dv);
    int n = 0;
    int per = dv + 1;
    set_div(16'(dv));
    bus_write(3'd2, 8'h01);
    bus_write(3'd0, b);
    while (tx_out !== 1'b0 && n < 200) begin @(negedge clock); n++; end
    for (int k = 0; k < 10 * per; k++) begin
      check($sformatf("tx_bit%0d_b%02h", k / per, b), {7'b0, tx_out}, {7'b0, frame_bit(b, k / per)});
      if (k == 10 * per - 1) check("tx_busy_last_clk", {7'b0, dbg_tx_state != 2'd0}, 8'h01);
      @(negedge clock);
    end
    check("tx_idle_after_frame", {6'b0, dbg_tx_state}, 8'h00);
    check("tx_line_idle", {7'b0, tx_out}, 8'h01);
  endtask

  task automatic drive_rx_frame(input logic [7:0] b, input logic stop, input int dv);
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      rx_in = (k == 9) ? stop : frame_bit(b, k);
      repeat (dv) @(negedge clock);
    end
    @(negedge clock);
    rx_in = 1'b1;
  endtask

  initial begin
    logic [7:0] b, got;
    logic [7:0] ov[6];
    logic       lb_low, saw_start;
    int         dv, accepted, kept;

    reset = 1'b0; cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = '0; in_data = '0; rx_in = 1'b1;
    repeat (20) @(negedge clock);
    check("rst_tx_out", {7'b0, tx_out}, 8'h01);
    check("rst_irq", {7'b0, irq}, 8'h00);
    check("rst_irq_id", {5'b0, irq_id}, 8'h00);
    check("rst_out_data", out_data, 8'h00);
    reset = 1'b1;
    read_check("rst_div_lo", 3'd3, 8'hB1);
    read_check("rst_div_hi", 3'd4, 8'h01);
    read_check("rst_status", 3'd1, 8'h04);
    read_check("rst_ctrl", 3'd2, 8'h00);
    read_check("rst_empty_pop", 3'd0, 8'h00);

    check_tx_frame(8'hA5, 3);
    read_check("tx_status_after", 3'd1, 8'h04);
    read_check("div_lo_readback", 3'd3, 8'h03);
    for (int i = 0; i < 2; i++) check_tx_frame(8'($urandom), $urandom_range(1, 4));

    set_div(16'd3);
    bus_write(3'd2, 8'h0F);
    bus_write(3'd0, 8'h3C);
    lb_low = 1'b0;
    for (int n = 0; n < 200 && irq !== 1'b1; n++) begin
      if (tx_out === 1'b0) lb_low = 1'b1;
      @(negedge clock);
    end
    check("lb_tx_out_held", {7'b0, lb_low}, 8'h00);
    check("lb_irq", {7'b0, irq}, 8'h01);
    check("lb_irq_id", {5'b0, irq_id}, 8'h02);
    read_check("lb_rx_lvl", 3'd6, 8'h01);
    read_check("lb_data", 3'd0, 8'h3C);
    check("lb_irq_pop_clk", {7'b0, irq}, 8'h01);
    @(negedge clock);
    check("lb_irq_dropped", {7'b0, irq}, 8'h00);

    for (int i = 0; i < 6; i++) begin
      dv = $urandom_range(1, 6);
      b  = 8'($urandom);
      set_div(16'(dv));
      exp_q.push_back(b);
      bus_write(3'd0, b);
      wait_irq(300);
      check("lb_rand_irq", {7'b0, irq}, 8'h01);
      bus_read(3'd0, got);
      check("lb_rand_data", got, exp_q.pop_front());
    end

    repeat (80) @(negedge clock);
    set_div(16'd3);
    bus_write(3'd2, 8'h2F);
    for (int i = 0; i < 6; i++) begin
      ov[i] = 8'($urandom);
      bus_write(3'd0, ov[i]);
    end
    // First byte goes straight to the serialiser, DEPTH more fit in TX, RX keeps DEPTH.
    accepted = (6 < DEPTH + 1) ? 6 : DEPTH + 1;
    kept     = (accepted < DEPTH) ? accepted : DEPTH;
    for (int i = 0; i < kept; i++) exp_q.push_back(ov[i]);
    read_check("ovf_tx_lvl", 3'd7, 8'(DEPTH));
    read_check("ovf_status_tx", 3'd1, 8'hC8);
    repeat (260) @(negedge clock);
    read_check("ovf_status_rx", 3'd1, 8'h97);
    check("ovf_irq_id", {5'b0, irq_id}, 8'h01);
    read_check("ovf_irq_reg", 3'd5, 8'h01);
    bus_write(3'd5, 8'hF0);
    read_check("ovf_status_cleared", 3'd1, 8'h07);
    check("ovf_irq_id_rx", {5'b0, irq_id}, 8'h02);
    read_check("ovf_rx_lvl", 3'd6, 8'(kept));
    while (exp_q.size() > 0) begin
      bus_read(3'd0, got);
      check("ovf_data", got, exp_q.pop_front());
    end
    read_check("ovf_empty_pop", 3'd0, 8'h00);
    read_check("ovf_rx_lvl_zero", 3'd6, 8'h00);

    bus_write(3'd2, 8'h02);
    b = 8'($urandom);
    drive_rx_frame(b, 1'b0, 3);
    repeat (20) @(negedge clock);
    read_check("ferr_status", 3'd1, 8'h25);
    read_check("ferr_rx_lvl", 3'd6, 8'h01);
    read_check("ferr_data", 3'd0, b);
    bus_write(3'd5, 8'hF0);
    read_check("ferr_cleared", 3'd1, 8'h04);
    b = 8'($urandom);
    drive_rx_frame(b, 1'b1, 3);
    repeat (20) @(negedge clock);
    read_check("ext_status", 3'd1, 8'h05);
    read_check("ext_data", 3'd0, b);

    @(negedge clock); rx_in = 1'b0;
    @(negedge clock); rx_in = 1'b1;
    saw_start = 1'b0;
    for (int n = 0; n < 12; n++) begin
      if (dbg_rx_state !== 2'd0) saw_start = 1'b1;
      @(negedge clock);
    end
    check("glitch_start_seen", {7'b0, saw_start}, 8'h01);
    check("glitch_rx_idle", {6'b0, dbg_rx_state}, 8'h00);
    read_check("glitch_rx_lvl", 3'd6, 8'h00);

    bus_write(3'd2, 8'h01);
    read_check("pre_rst_div_lo", 3'd3, 8'h03);
    bus_write(3'd0, 8'h55);
    bus_write(3'd0, 8'hAA);
    for (int n = 0; n < 100 && tx_out !== 1'b0; n++) @(negedge clock);
    check("mid_tx_started", {7'b0, tx_out}, 8'h00);
    repeat (6) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_tx_out", {7'b0, tx_out}, 8'h01);
    check("mid_rst_out_data", out_data, 8'h00);
    check("mid_rst_tx_state", {6'b0, dbg_tx_state}, 8'h00);
    reset = 1'b1;
    read_check("mid_rst_tx_lvl", 3'd7, 8'h00);
    read_check("mid_rst_ctrl", 3'd2, 8'h00);
    read_check("mid_rst_div_lo", 3'd3, 8'hB1);
    check("mid_rst_line_idle", {7'b0, tx_out}, 8'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
